alu_seq_n: RTL and testbench

- Parametrised, clocked successor to the 32-bit integer ALU.
- Data width is generic.
- Operands and function select are captured under a start/busy/done handshake.
- Single-cycle ops finish in one clock. MUL and DIV run as iterative shift-add / restoring-divide engines over W cycles, replacing the combinational multiply and divide units.
- Sits in the integer datapath between the register file read ports and the HI/LO/writeback registers.

---
 rtl/alu_seq_n.sv | 217 +++++++++++++++++++++
 tb/tb_alu_seq_n.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_n.sv
// Sequential integer ALU: single-cycle ops plus iterative shift-add multiply and
// restoring divide, all behind a start/busy/done handshake.
module alu_seq_n #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [4:0]   FS,
   input  logic [W-1:0] S,
   input  logic [W-1:0] T,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Y_hi,
   output logic [W-1:0] Y_lo,
   output logic         C,
   output logic         V,
   output logic         N,
   output logic         Z
);

   localparam int SW = $clog2(W);
   localparam logic [4:0] OP_MUL = 5'h1E;
   localparam logic [4:0] OP_DIV = 5'h1F;

   // FIX applies sign correction after MUL/DIV; LOAD stages results so that
   // outputs only move on entry to DONE.
   typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIX, LOAD, DONE} state_t;

   state_t          state;
   logic [4:0]      fs_r;
   logic [W-1:0]    s_r, t_r, mag, hi_acc, lo_acc;
   logic [SW-1:0]   cnt;
   logic [W-1:0]    res_hi, res_lo;
   logic            res_c, res_v, res_n, res_z;

   function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
      return x[W-1] ? -x : x;
   endfunction

   logic [W-1:0] sc_lo, opb;
   logic         sc_c, sc_v, sub, arith, signed_op, ovf;
   logic [W:0]   sum;
   logic [SW-1:0] sh;

   always_comb begin
      opb       = t_r;
      sub       = 1'b0;
      arith     = 1'b0;
      signed_op = 1'b0;
      sh        = s_r[SW-1:0];
      case (fs_r)
         5'h02: begin arith = 1'b1; signed_op = 1'b1; end
         5'h03: arith = 1'b1;
         5'h04: begin arith = 1'b1; sub = 1'b1; signed_op = 1'b1; end
         5'h05: begin arith = 1'b1; sub = 1'b1; end
         5'h0F: begin arith = 1'b1; signed_op = 1'b1; opb = W'(1); end
         5'h10: begin arith = 1'b1; signed_op = 1'b1; opb = W'(4); end
         5'h11: begin arith = 1'b1; signed_op = 1'b1; sub = 1'b1; opb = W'(1); end
         5'h12: begin arith = 1'b1; signed_op = 1'b1; sub = 1'b1; opb = W'(4); end
         default: ;
      endcase
      // Subtract as S + ~B + 1 so the carry out is the no-borrow (S >= B) flag.
      sum = {1'b0, s_r} + {1'b0, (sub ? ~opb : opb)} + {{W{1'b0}}, sub};
      if (sub)
         ovf = (s_r[W-1] != opb[W-1]) && (sum[W-1] != s_r[W-1]);
      else
         ovf = (s_r[W-1] == opb[W-1]) && (sum[W-1] != s_r[W-1]);
      case (fs_r)
         5'h00: sc_lo = s_r;
         5'h01: sc_lo = t_r;
         5'h02, 5'h03, 5'h04, 5'h05,
         5'h0F, 5'h10, 5'h11, 5'h12: sc_lo = sum[W-1:0];
         5'h06: sc_lo = {{(W-1){1'b0}}, ($signed(s_r) < $signed(t_r))};
         5'h07: sc_lo = {{(W-1){1'b0}}, (s_r < t_r)};
         5'h08: sc_lo = s_r & t_r;
         5'h09: sc_lo = s_r | t_r;
         5'h0A: sc_lo = s_r ^ t_r;
         5'h0B: sc_lo = ~(s_r | t_r);
         5'h0C: sc_lo = t_r >> sh;
         5'h0D: sc_lo = $signed(t_r) >>> sh;
         5'h0E: sc_lo = t_r << sh;
         5'h14: sc_lo = '1;
         default: sc_lo = '0;
      endcase
      sc_c = arith & sum[W];
      sc_v = signed_op & ovf;
   end

   logic [W:0]     mul_sum, div_sh;
   logic [W-1:0]   div_rem;
   logic           div_ok, neg_q;
   logic [2*W-1:0] mul_res;
   logic [W-1:0]   quo, rem;

   always_comb begin
      mul_sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, mag} : '0);
      div_sh  = {hi_acc, lo_acc[W-1]};
      div_ok  = (div_sh >= {1'b0, mag});
      div_rem = div_sh[W-1:0] - mag;
      neg_q   = s_r[W-1] ^ t_r[W-1];
      mul_res = neg_q ? -{hi_acc, lo_acc} : {hi_acc, lo_acc};
      quo     = neg_q ? -lo_acc : lo_acc;
      rem     = s_r[W-1] ? -hi_acc : hi_acc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         Y_hi   <= '0;
         Y_lo   <= '0;
         C      <= 1'b0;
         V      <= 1'b0;
         N      <= 1'b0;
         Z      <= 1'b0;
         fs_r   <= '0;
         s_r    <= '0;
         t_r    <= '0;
         mag    <= '0;
         hi_acc <= '0;
         lo_acc <= '0;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         res_c  <= 1'b0;
         res_v  <= 1'b0;
         res_n  <= 1'b0;
         res_z  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               s_r    <= S;
               t_r    <= T;
               fs_r   <= FS;
               busy   <= 1'b1;
               cnt    <= SW'(W - 1);
               hi_acc <= '0;
               if (FS == OP_MUL) begin
                  mag    <= mag_of(S);
                  lo_acc <= mag_of(T);
                  state  <= MUL;
               end else if (FS == OP_DIV && T != '0) begin
                  mag    <= mag_of(T);
                  lo_acc <= mag_of(S);
                  state  <= DIV;
               end else begin
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (fs_r == OP_DIV) begin
                  res_lo <= '1;
                  res_hi <= s_r;
                  res_c  <= 1'b0;
                  res_v  <= 1'b1;
                  res_n  <= 1'b1;
                  res_z  <= 1'b0;
               end else begin
                  res_lo <= sc_lo;
                  res_hi <= '0;
                  res_c  <= sc_c;
                  res_v  <= sc_v;
                  res_n  <= sc_lo[W-1];
                  res_z  <= (sc_lo == '0);
               end
               state <= LOAD;
            end
            MUL: begin
               {hi_acc, lo_acc} <= {mul_sum, lo_acc[W-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            DIV: begin
               hi_acc <= div_ok ? div_rem : div_sh[W-1:0];
               lo_acc <= {lo_acc[W-2:0], div_ok};
               cnt    <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               res_c <= 1'b0;
               if (fs_r == OP_MUL) begin
                  {res_hi, res_lo} <= mul_res;
                  res_v <= 1'b0;
                  res_n <= mul_res[2*W-1];
                  res_z <= (mul_res == '0);
               end else begin
                  res_lo <= quo;
                  res_hi <= rem;
                  res_v  <= (s_r == {1'b1, {(W-1){1'b0}}}) && (t_r == '1);
                  res_n  <= quo[W-1];
                  res_z  <= (quo == '0);
               end
               state <= LOAD;
            end
            LOAD: begin
               Y_hi  <= res_hi;
               Y_lo  <= res_lo;
               C     <= res_c;
               V     <= res_v;
               N     <= res_n;
               Z     <= res_z;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed plus randomized bench for alu_seq_n against an arithmetic reference model.
module tb_alu_seq_n;

   localparam int W = 32;
   localparam longint MAXI = 64'sd2147483647;
   localparam longint MINI = -64'sd2147483648;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [4:0]   FS;
   logic [W-1:0] S, T;
   logic         busy, done, C, V, N, Z;
   logic [W-1:0] Y_hi, Y_lo;

   int total = 0;
   int bad   = 0;
   logic [31:0] prev_lo = '0;

   alu_seq_n #(.W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .FS(FS), .S(S), .T(T),
      .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo),
      .C(C), .V(V), .N(N), .Z(Z)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi, lo;
      logic        c, v, n, z;
      int          lat;
   } res_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
      res_t r;
      longint ss, st, q, rm, p;
      longint unsigned su, tu;
      logic [63:0] w;
      ss = longint'($signed(s));
      st = longint'($signed(t));
      su = {32'b0, s};
      tu = {32'b0, t};
      r.hi = '0; r.lo = '0; r.c = 1'b0; r.v = 1'b0; r.n = 1'b0; r.z = 1'b0; r.lat = 2;
      case (fs)
         5'h00: r.lo = s;
         5'h01: r.lo = t;
         5'h02, 5'h03: begin
            w = su + tu; r.lo = w[31:0]; r.c = w[32];
            if (fs == 5'h02) r.v = (ss + st > MAXI) || (ss + st < MINI);
         end
         5'h04, 5'h05: begin
            w = su - tu; r.lo = w[31:0]; r.c = (su >= tu);
            if (fs == 5'h04) r.v = (ss - st > MAXI) || (ss - st < MINI);
         end
         5'h06: r.lo = 32'(ss < st);
         5'h07: r.lo = 32'(su < tu);
         5'h08: r.lo = s & t;
         5'h09: r.lo = s | t;
         5'h0A: r.lo = s ^ t;
         5'h0B: r.lo = ~(s | t);
         5'h0C: r.lo = t >> s[4:0];
         5'h0D: begin w = st >>> s[4:0]; r.lo = w[31:0]; end
         5'h0E: r.lo = t << s[4:0];
         5'h0F: begin w = su + 1; r.lo = w[31:0]; r.c = w[32]; r.v = (ss + 1 > MAXI); end
         5'h10: begin w = su + 4; r.lo = w[31:0]; r.c = w[32]; r.v = (ss + 4 > MAXI); end
         5'h11: begin w = su - 1; r.lo = w[31:0]; r.c = (su >= 1); r.v = (ss - 1 < MINI); end
         5'h12: begin w = su - 4; r.lo = w[31:0]; r.c = (su >= 4); r.v = (ss - 4 < MINI); end
         5'h14: r.lo = 32'hFFFF_FFFF;
         5'h1E: begin
            p = ss * st; w = p; r.hi = w[63:32]; r.lo = w[31:0]; r.lat = 34;
         end
         5'h1F: begin
            if (t == 0) begin
               r.lo = 32'hFFFF_FFFF; r.hi = s; r.v = 1'b1;
            end else begin
               q = ss / st; rm = ss % st;
               w = q;  r.lo = w[31:0];
               w = rm; r.hi = w[31:0];
               r.v = (q > MAXI); r.lat = 34;
            end
         end
         default: ;
      endcase
      if (fs == 5'h1E) begin
         r.n = r.hi[31]; r.z = (r.hi == 0) && (r.lo == 0);
      end else if (fs == 5'h1F && t == 0) begin
         r.n = 1'b1; r.z = 1'b0;
      end else begin
         r.n = r.lo[31]; r.z = (r.lo == 0);
      end
      return r;
   endfunction

   task automatic run_op(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t, input bit pulses);
      res_t  e;
      int    cnt;
      string tg;
      e  = model(fs, s, t);
      tg = $sformatf("op%02h s=%h t=%h", fs, s, t);
      @(negedge clk);
      FS = fs; S = s; T = t; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tg, " busy_on_accept"}, 64'(busy), 64'(1));
      cnt = 0;
      while (done !== 1'b1 && cnt < 200) begin
         if (cnt == 1) chk({tg, " y_lo_stable"}, 64'(Y_lo), 64'(prev_lo));
         if (pulses && (cnt == 5 || cnt == 20)) begin
            start = 1'b1; FS = 5'h02; S = 32'h1111_1111; T = 32'h2222_2222;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cnt++;
      end
      start = 1'b0;
      chk({tg, " latency"}, 64'(cnt), 64'(e.lat));
      chk({tg, " busy_in_done"}, 64'(busy), 64'(1));
      chk({tg, " y_hi"}, 64'(Y_hi), 64'(e.hi));
      chk({tg, " y_lo"}, 64'(Y_lo), 64'(e.lo));
      chk({tg, " c"}, 64'(C), 64'(e.c));
      chk({tg, " v"}, 64'(V), 64'(e.v));
      chk({tg, " n"}, 64'(N), 64'(e.n));
      chk({tg, " z"}, 64'(Z), 64'(e.z));
      if (pulses) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tg, " done_pulse_end"}, 64'(done), 64'(0));
      chk({tg, " busy_after_done"}, 64'(busy), 64'(0));
      prev_lo = e.lo;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int ndone;
      reset = 1'b1; start = 1'b1; FS = 5'h02; S = 32'h5; T = 32'h6;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset busy", 64'(busy), 64'(0));
      chk("post_reset done", 64'(done), 64'(0));
      chk("post_reset y", {Y_hi, Y_lo}, 64'(0));
      chk("post_reset flags", 64'({C, V, N, Z}), 64'(0));

      run_op(5'h02, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(5'h03, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(5'h1E, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      run_op(5'h1F, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      run_op(5'h1F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(5'h1F, 32'h0000_0123, 32'h0000_0000, 1'b0);

      // abort a divide partway through
      @(negedge clk);
      FS = 5'h1F; S = 32'h0001_E240; T = 32'h0000_0007; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort busy", 64'(busy), 64'(0));
      chk("abort done", 64'(done), 64'(0));
      chk("abort y", {Y_hi, Y_lo}, 64'(0));
      chk("abort flags", 64'({C, V, N, Z}), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      chk("abort no_done", 64'(ndone), 64'(0));
      prev_lo = '0;

      run_op(5'h0D, 32'h0000_0004, 32'hF000_0000, 1'b0);

      repeat (80) begin
         logic [4:0] f;
         f = 5'($urandom_range(0, 31));
         run_op(f, pick(), pick(), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
